// File: rtl/async_ram_ctrl_if.sv
// Host request/response channel of async_ram_ctrl.
// master = host side, slave = controller side.
interface async_ram_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/async_ram_ctrl.sv
// Asynchronous SRAM controller with programmable setup/pulse/hold phases.
// Define ASYNC_RAM_CTRL_VERIFY_EN to append a read-back verify to every write.
module async_ram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    async_ram_ctrl_if.slave       bus,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
`ifdef ASYNC_RAM_CTRL_VERIFY_EN
        ,
        VSETUP,
        VACCESS,
        VHOLD
`endif
    } state_t;

    // Counters are loaded with (length - 1) and the phase ends when they reach zero.
    localparam logic [3:0] SETUP_RL = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_RL = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_RL  = 4'(HOLD_CYC - 1);

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic                  we_q, we_n;
    logic                  ready_q, ready_n;
    logic                  cs_n, wen_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] din_n;
    logic                  rvalid_q, rvalid_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
`ifdef ASYNC_RAM_CTRL_VERIFY_EN
    logic                  verr_q, verr_n;
    logic                  err_q, err_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            ready_q  <= 1'b0;
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
`ifdef ASYNC_RAM_CTRL_VERIFY_EN
            verr_q   <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            we_q     <= we_n;
            ready_q  <= ready_n;
            ram_cs   <= cs_n;
            ram_we   <= wen_n;
            ram_addr <= addr_n;
            ram_din  <= din_n;
            rvalid_q <= rvalid_n;
            rdata_q  <= rdata_n;
`ifdef ASYNC_RAM_CTRL_VERIFY_EN
            verr_q   <= verr_n;
            err_q    <= err_n;
`endif
        end
    end

    // Every output is computed one cycle ahead so that all of them leave flops.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        we_n     = we_q;
        cs_n     = ram_cs;
        wen_n    = ram_we;
        addr_n   = ram_addr;
        din_n    = ram_din;
        rvalid_n = 1'b0;
        rdata_n  = rdata_q;
`ifdef ASYNC_RAM_CTRL_VERIFY_EN
        verr_n   = verr_q;
        err_n    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                cs_n  = 1'b0;
                wen_n = 1'b0;
                if (bus.req_valid && ready_q) begin
                    we_n    = bus.req_we;
                    addr_n  = bus.req_addr;
                    din_n   = bus.req_wdata;
                    cs_n    = 1'b1;
                    state_n = SETUP;
                    cnt_n   = SETUP_RL;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = ACCESS;
                    cnt_n   = PULSE_RL;
                    wen_n   = we_q;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_RL;
                    wen_n   = 1'b0;
                    if (!we_q) rdata_n = ram_dout;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
`ifdef ASYNC_RAM_CTRL_VERIFY_EN
                    if (we_q) begin
                        state_n = VSETUP;
                        cnt_n   = SETUP_RL;
                    end else
`endif
                    begin
                        state_n  = IDLE;
                        cs_n     = 1'b0;
                        rvalid_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
`ifdef ASYNC_RAM_CTRL_VERIFY_EN
            VSETUP: begin
                if (cnt == '0) begin
                    state_n = VACCESS;
                    cnt_n   = PULSE_RL;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            VACCESS: begin
                if (cnt == '0) begin
                    state_n = VHOLD;
                    cnt_n   = HOLD_RL;
                    verr_n  = (ram_dout != ram_din);
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            VHOLD: begin
                if (cnt == '0) begin
                    state_n  = IDLE;
                    cs_n     = 1'b0;
                    rvalid_n = 1'b1;
                    err_n    = verr_q;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                cs_n    = 1'b0;
                wen_n   = 1'b0;
            end
        endcase
        ready_n = (state_n == IDLE);
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rvalid_q;
    assign bus.rsp_rdata = rdata_q;
`ifdef ASYNC_RAM_CTRL_VERIFY_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_async_ram_ctrl.sv
// Directed bench for async_ram_ctrl: default-timing DUT plus a SETUP=3/PULSE=1/HOLD=2 DUT,
// each attached to a behavioural asynchronous RAM.
module tb_async_ram_ctrl;

`ifdef ASYNC_RAM_CTRL_VERIFY_EN
    localparam int WR_LAT0 = 8;
    localparam int WR_CS0  = 8;
    localparam int WR_LAT1 = 12;
    localparam int WR_CS1  = 12;
`else
    localparam int WR_LAT0 = 4;
    localparam int WR_CS0  = 4;
    localparam int WR_LAT1 = 6;
    localparam int WR_CS1  = 6;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    async_ram_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus0 ();
    async_ram_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus1 ();

    logic        cs0, we0, cs1, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] din0, din1, dout0, dout1;
    logic        force0 = 1'b0;
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    async_ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .ram_cs(cs0), .ram_we(we0), .ram_addr(addr0), .ram_din(din0), .ram_dout(dout0)
    );

    async_ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .ram_cs(cs1), .ram_we(we1), .ram_addr(addr1), .ram_din(din1), .ram_dout(dout1)
    );

    always @(posedge clk) begin
        if (cs0 && we0) mem0[addr0] <= din0;
        if (cs1 && we1) mem1[addr1] <= din1;
    end
    assign dout0 = force0 ? 16'h0000 : mem0[addr0];
    assign dout1 = mem1[addr1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus0.req_ready : bus1.req_ready;
    endfunction

    task automatic drive_req(input int sel, input logic v, input logic we, input logic [7:0] a, input logic [15:0] d);
        if (sel == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = a; bus1.req_wdata = d;
        end
    endtask

    task automatic wait_ready(input int sel);
        int n = 0;
        while (!get_ready(sel) && n < 50) begin
            @(posedge clk); #1; n++;
        end
    endtask

    // One transfer; lat counts edges from the accept edge to the edge raising rsp_valid.
    task automatic xfer(input int sel, input logic we, input logic [7:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output logic er,
                        output int wecnt, output int cscnt, output int wefirst, output logic stable);
        logic cs, wen, rv;
        logic [7:0] ad;
        logic [15:0] dn;
        wait_ready(sel);
        drive_req(sel, 1'b1, we, a, d);
        @(posedge clk); #1;
        drive_req(sel, 1'b0, 1'b0, 8'h00, 16'h0000);
        lat = 0; wecnt = 0; cscnt = 0; wefirst = -1; stable = 1'b1;
        rd = '0; er = 1'b0;
        forever begin
            cs  = (sel == 0) ? cs0 : cs1;
            wen = (sel == 0) ? we0 : we1;
            ad  = (sel == 0) ? addr0 : addr1;
            dn  = (sel == 0) ? din0 : din1;
            rv  = (sel == 0) ? bus0.rsp_valid : bus1.rsp_valid;
            if (cs) begin
                cscnt++;
                if (ad !== a || dn !== d) stable = 1'b0;
            end
            if (wen) begin
                if (wefirst < 0) wefirst = lat;
                wecnt++;
            end
            if (rv) begin
                rd = (sel == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
                er = (sel == 0) ? bus0.rsp_err : bus1.rsp_err;
                break;
            end
            if (lat >= 40) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat, wecnt, cscnt, wefirst;
        logic [15:0] rd;
        logic er, stable;

        vecs[0] = '{1'b1, 8'h05, 16'hAAAA, 16'h0000};
        vecs[1] = '{1'b1, 8'h06, 16'h5555, 16'h0000};
        vecs[2] = '{1'b1, 8'h07, 16'hF00D, 16'h0000};
        vecs[3] = '{1'b0, 8'h05, 16'h0000, 16'hAAAA};
        vecs[4] = '{1'b0, 8'h06, 16'h0000, 16'h5555};
        vecs[5] = '{1'b0, 8'h07, 16'h0000, 16'hF00D};
        vecs[6] = '{1'b1, 8'h00, 16'hFFFF, 16'h0000};
        vecs[7] = '{1'b1, 8'hFF, 16'h0001, 16'h0000};
        vecs[8] = '{1'b0, 8'hFF, 16'h0000, 16'h0001};
        vecs[9] = '{1'b0, 8'h00, 16'h0000, 16'hFFFF};

        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        drive_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_ready", 32'(bus0.req_ready), 0);
        check("rst_outs", {bus0.rsp_valid, bus0.rsp_err, cs0, we0, addr0, din0}, 0);
        check("rst_rdata", 32'(bus0.rsp_rdata), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(bus0.req_ready), 1);

        // Table-driven writes and reads
        for (int i = 0; i < 10; i++) begin
            xfer(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, er, wecnt, cscnt, wefirst, stable);
            if (vecs[i].we) begin
                check($sformatf("wr_lat[%0d]", i), 32'(lat), 32'(WR_LAT0));
                check($sformatf("wr_err[%0d]", i), 32'(er), 0);
            end else begin
                check($sformatf("rd_lat[%0d]", i), 32'(lat), 4);
                check($sformatf("rd_data[%0d]", i), 32'(rd), 32'(vecs[i].exp_rdata));
            end
        end

        // Single write waveform shape
        xfer(0, 1'b1, 8'h20, 16'h1234, lat, rd, er, wecnt, cscnt, wefirst, stable);
        check("wave_cs_width", 32'(cscnt), 32'(WR_CS0));
        check("wave_we_width", 32'(wecnt), 2);
        check("wave_we_start", 32'(wefirst), 1);
        check("wave_stable", 32'(stable), 1);

        // req_valid held high for three reads
        begin
            int cyc, nacc, cslow, nrsp;
            int acc [3];
            logic prev_rdy;
            wait_ready(0);
            drive_req(0, 1'b1, 1'b0, 8'h05, 16'h0000);
            prev_rdy = bus0.req_ready;
            cyc = 0; nacc = 0; cslow = 0; nrsp = 0;
            acc[0] = 0; acc[1] = 0; acc[2] = 0;
            while (cyc < 60 && nrsp < 3) begin
                @(posedge clk); #1;
                cyc++;
                if (prev_rdy && bus0.req_valid && nacc < 3) begin
                    acc[nacc] = cyc;
                    nacc++;
                    if (nacc == 3) bus0.req_valid = 1'b0;
                end
                if ((nacc == 1 || nacc == 2) && !cs0) cslow++;
                if (bus0.rsp_valid) begin
                    nrsp++;
                    check("b2b_rdata", 32'(bus0.rsp_rdata), 32'hAAAA);
                end
                prev_rdy = bus0.req_ready;
            end
            bus0.req_valid = 1'b0;
            check("b2b_gap1", 32'(acc[1] - acc[0]), 5);
            check("b2b_gap2", 32'(acc[2] - acc[1]), 5);
            check("b2b_cs_low", 32'(cslow), 2);
            check("b2b_nrsp", 32'(nrsp), 3);
        end

        // Reset during the ACCESS phase of a write
        begin
            int nrv = 0;
            wait_ready(0);
            drive_req(0, 1'b1, 1'b1, 8'h10, 16'hBEEF);
            @(posedge clk); #1;
            drive_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
            @(posedge clk); #1;
            check("pre_rst_access", {cs0, we0}, 2'b11);
            rst_n = 1'b0;
            #1;
            check("async_rst_cs_we", {cs0, we0}, 2'b00);
            check("async_rst_ready", 32'(bus0.req_ready), 0);
            @(posedge clk); #1;
            if (bus0.rsp_valid) nrv++;
            #3 rst_n = 1'b1;
            @(posedge clk); #1;
            check("rst_release_ready", 32'(bus0.req_ready), 1);
            repeat (5) begin
                if (bus0.rsp_valid) nrv++;
                @(posedge clk); #1;
            end
            check("rst_no_rsp", 32'(nrv), 0);
            xfer(0, 1'b0, 8'h10, 16'h0000, lat, rd, er, wecnt, cscnt, wefirst, stable);
            check("rst_next_rd_lat", 32'(lat), 4);
        end

`ifdef ASYNC_RAM_CTRL_VERIFY_EN
        // Verify read sees corrupted data, then clean data
        force0 = 1'b1;
        xfer(0, 1'b1, 8'h05, 16'hAAAA, lat, rd, er, wecnt, cscnt, wefirst, stable);
        force0 = 1'b0;
        check("vfy_bad_lat", 32'(lat), 8);
        check("vfy_bad_err", 32'(er), 1);
        xfer(0, 1'b1, 8'h05, 16'hAAAA, lat, rd, er, wecnt, cscnt, wefirst, stable);
        check("vfy_ok_lat", 32'(lat), 8);
        check("vfy_ok_err", 32'(er), 0);
`endif

        // Non-default timing: SETUP=3, PULSE=1, HOLD=2
        xfer(1, 1'b1, 8'h33, 16'h1357, lat, rd, er, wecnt, cscnt, wefirst, stable);
        check("p2_wr_lat", 32'(lat), 32'(WR_LAT1));
        check("p2_we_width", 32'(wecnt), 1);
        check("p2_we_start", 32'(wefirst), 3);
        check("p2_cs_width", 32'(cscnt), 32'(WR_CS1));
        check("p2_stable", 32'(stable), 1);
        xfer(1, 1'b0, 8'h33, 16'h0000, lat, rd, er, wecnt, cscnt, wefirst, stable);
        check("p2_rd_lat", 32'(lat), 6);
        check("p2_rd_data", 32'(rd), 32'h1357);
        check("p2_rd_we", 32'(wecnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_ram_ctrl.md
ASYNC_RAM_CTRL -- requirements
Module: async_ram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of the RAM address.
REQ-002 Parameter DATA_WIDTH, default 16, width of the RAM data.
REQ-003 Parameter SETUP_CYC, default 1, cycles from address/CS valid to WE assertion; legal range 1-15.
REQ-004 Parameter PULSE_CYC, default 2, cycles of the access (WE pulse or read window); legal range 1-15.
REQ-005 Parameter HOLD_CYC, default 1, cycles that CS/address/data are held after the access; legal range 1-15.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 req_valid  in  1  host request present.
REQ-009 req_ready  out  1  controller can accept a request.
REQ-010 req_we  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  ADDR_WIDTH  request address.
REQ-012 req_wdata  in  DATA_WIDTH  write data.
REQ-013 rsp_valid  out  1  one-cycle completion pulse, for both reads and writes.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data; valid while rsp_valid=1 after a read.
REQ-015 rsp_err  out  1  write-verify mismatch, qualified by rsp_valid.
REQ-016 ram_cs, ram_we  out  1 each  RAM chip select and write enable, both registered.
REQ-017 ram_addr, ram_din  out  ADDR_WIDTH, DATA_WIDTH  RAM address and write data, both registered.
REQ-018 ram_dout  in  DATA_WIDTH  asynchronous RAM read data.

Function
REQ-019 States are IDLE, SETUP, ACCESS, HOLD, plus VSETUP, VACCESS, VHOLD when the verify option is compiled in.
REQ-020 req_ready=1 only in IDLE; a transfer is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-021 On acceptance, the block latches req_we, req_addr and req_wdata into ram_addr/ram_din, sets ram_cs=1, and enters SETUP.
REQ-022 SETUP lasts SETUP_CYC cycles with ram_we=0, then the FSM enters ACCESS.
REQ-023 ACCESS lasts PULSE_CYC cycles, with ram_we=latched req_we.
REQ-024 On the last ACCESS edge of a read, ram_dout is captured into rsp_rdata.
REQ-025 HOLD lasts HOLD_CYC cycles with ram_we=0 and ram_cs=1, then the FSM returns to IDLE with rsp_valid=1 for exactly one cycle.
REQ-026 Latency from the accept edge to the edge that raises rsp_valid is SETUP_CYC+PULSE_CYC+HOLD_CYC edges (4 with defaults).
REQ-027 ram_addr and ram_din SHALL NOT change while ram_cs=1, and ram_we SHALL be 0 in the first SETUP cycle and the first HOLD cycle.
REQ-028 Back-to-back: a request may be accepted in the same IDLE cycle in which rsp_valid=1, giving ram_cs low for exactly one cycle between transfers.
REQ-029 In IDLE, ram_cs=0 and ram_we=0, ram_addr/ram_din keep their last values, and rsp_rdata holds until the next read capture.
REQ-030 Requests presented while req_ready=0 are ignored, not queued.
REQ-031 Phase counters are 4-bit, reload on every state entry, and never wrap within a phase.

Reset
REQ-032 While rst_n=0, all outputs are 0 and the state is IDLE, asynchronously: ram_cs and ram_we drop without waiting for a clock.
REQ-033 Reset mid-transfer abandons the transfer with no rsp_valid, and req_ready=1 on the first edge after rst_n rises.

Configuration
REQ-034 Macro ASYNC_RAM_CTRL_VERIFY_EN defined: after a write's HOLD, the block performs a read of the same address through VSETUP/VACCESS/VHOLD (same cycle counts, ram_we=0, ram_cs=1 throughout), compares ram_dout on the last VACCESS edge with the written data, and pulses rsp_valid with rsp_err=1 on mismatch; write latency is 2x(SETUP_CYC+PULSE_CYC+HOLD_CYC).
REQ-035 Macro undefined: V-states are absent, rsp_err is constant 0, and write latency equals read latency.

Verification
REQ-036 Writes 0x05=AAAA, 0x06=5555, 0x07=F00D, then reads of 0x05/0x06/0x07 -> rsp_rdata AAAA/5555/F00D, each rsp_valid 4 edges after accept.
REQ-037 Single write with defaults -> ram_cs high 4 cycles, ram_we high exactly 2 cycles starting 1 cycle after ram_cs rises, ram_addr/ram_din stable throughout.
REQ-038 req_valid held high for 3 reads -> transfers accepted every 5 cycles, ram_cs low exactly 1 cycle between them.
REQ-039 rst_n low during ACCESS of a write to 0x10 -> ram_cs/ram_we low immediately, no rsp_valid, and the next read of 0x10 is accepted after release.
REQ-040 VERIFY_EN with ram_dout forced to 0000 during the verify read of a 0x05=AAAA write -> rsp_valid with rsp_err=1 after 8 edges; unforced -> rsp_err=0.
REQ-041 Parameters SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2 -> read latency 6 edges and ram_we pulse width 1 cycle on writes.
